// File: rtl/ball_bouncer.sv
// ball_bouncer: square ball bouncing inside the visible area, one step per video frame.
// Ports:
//   i_clk          system clock (sole clock domain)
//   i_rst          synchronous active-high reset
//   i_vsync        vertical sync from the video sync generator
//   i_visible      current pixel is in the visible area
//   i_hpos/i_vpos  current pixel column/row
//   o_rgb          registered pixel colour {B,G,R}, 1-cycle latency
//   o_ball_x/y     ball top-left position
//   o_bounce       one-cycle pulse per reflection event (corner counts once)
//   o_bounce_count reflection event counter, wraps 255->0
// Macro BALL_COLOR_CYCLE_EN: ball colour starts at 001 and advances on each
// reflection, skipping 000; otherwise the colour is constant white.
module ball_bouncer #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int BALL_SIZE = 8,
    parameter int H_SPEED   = 2,
    parameter int V_SPEED   = 2,
    parameter int INIT_X    = 128,
    parameter int INIT_Y    = 128
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_vsync,
    input  logic       i_visible,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    output logic [2:0] o_rgb,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic       o_bounce,
    output logic [7:0] o_bounce_count
);
    localparam logic [10:0] X_MAX = 11'(H_VISIBLE - BALL_SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_VISIBLE - BALL_SIZE);
    localparam logic [10:0] HS    = 11'(H_SPEED);
    localparam logic [10:0] VS    = 11'(V_SPEED);
    localparam logic [10:0] SZ    = 11'(BALL_SIZE);

    logic        vsync_q, tick_q, bounce_q, dir_x, dir_y;
    logic        hit_x, hit_y, in_ball;
    logic [10:0] bx, by, x_nxt, y_nxt;
    logic [2:0]  color;

    // 11-bit arithmetic keeps x+speed and x+size from wrapping before compare
    always_comb begin
        bx      = {1'b0, o_ball_x};
        by      = {1'b0, o_ball_y};
        hit_x   = dir_x ? (bx <= HS) : (bx + HS >= X_MAX);
        hit_y   = dir_y ? (by <= VS) : (by + VS >= Y_MAX);
        x_nxt   = hit_x ? (dir_x ? 11'd0 : X_MAX) : (dir_x ? bx - HS : bx + HS);
        y_nxt   = hit_y ? (dir_y ? 11'd0 : Y_MAX) : (dir_y ? by - VS : by + VS);
        in_ball = ({1'b0, i_hpos} >= bx) && ({1'b0, i_hpos} < bx + SZ) &&
                  ({1'b0, i_vpos} >= by) && ({1'b0, i_vpos} < by + SZ);
    end

`ifdef BALL_COLOR_CYCLE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            color <= 3'b001;
        else if (tick_q && (hit_x || hit_y))
            color <= (color == 3'b111) ? 3'b001 : color + 3'd1;
    end
`else
    assign color = 3'b111;
`endif

    // tick_q marks the cycle after the vsync rising edge; the move happens then,
    // and the bounce pulse follows one cycle later via bounce_q.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vsync_q        <= 1'b1;
            tick_q         <= 1'b0;
            bounce_q       <= 1'b0;
            o_bounce       <= 1'b0;
            o_bounce_count <= 8'd0;
            o_ball_x       <= 10'(INIT_X);
            o_ball_y       <= 10'(INIT_Y);
            dir_x          <= 1'b0;
            dir_y          <= 1'b0;
            o_rgb          <= 3'b000;
        end else begin
            vsync_q  <= i_vsync;
            tick_q   <= i_vsync && !vsync_q;
            bounce_q <= tick_q && (hit_x || hit_y);
            o_bounce <= bounce_q;
            o_rgb    <= (i_visible && in_ball) ? color : 3'b000;
            if (tick_q) begin
                o_ball_x       <= x_nxt[9:0];
                o_ball_y       <= y_nxt[9:0];
                dir_x          <= dir_x ^ hit_x;
                dir_y          <= dir_y ^ hit_y;
                o_bounce_count <= o_bounce_count + 8'(hit_x || hit_y);
            end
        end
    end
endmodule

// File: tb/tb_ball_bouncer.sv
// tb_ball_bouncer: directed self-checking bench for ball_bouncer using four
// differently parameterised instances that share clock, reset and sync inputs.
module tb_ball_bouncer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic       visible = 1'b0;
    logic [9:0] hpos = 10'd0;
    logic [9:0] vpos = 10'd0;
    int         checks = 0;
    int         errors = 0;

    logic [2:0] rgb0, rgb1, rgb2, rgb3;
    logic [9:0] x0, y0, x1, y1, x2, y2, x3, y3;
    logic       b0, b1, b2, b3;
    logic [7:0] c0, c1, c2, c3;
    int         nb0 = 0, nb1 = 0, nb2 = 0, nb3 = 0;

`ifdef BALL_COLOR_CYCLE_EN
    localparam logic [2:0] COL0 = 3'b001;
    localparam logic [2:0] COL_CORNER = 3'b010;
`else
    localparam logic [2:0] COL0 = 3'b111;
    localparam logic [2:0] COL_CORNER = 3'b111;
`endif

    always #5 clk = ~clk;

    ball_bouncer d0 (.i_clk(clk), .i_rst(rst), .i_vsync(vsync), .i_visible(visible),
        .i_hpos(hpos), .i_vpos(vpos), .o_rgb(rgb0), .o_ball_x(x0), .o_ball_y(y0),
        .o_bounce(b0), .o_bounce_count(c0));
    ball_bouncer #(.INIT_X(628)) d1 (.i_clk(clk), .i_rst(rst), .i_vsync(vsync),
        .i_visible(visible), .i_hpos(hpos), .i_vpos(vpos), .o_rgb(rgb1), .o_ball_x(x1),
        .o_ball_y(y1), .o_bounce(b1), .o_bounce_count(c1));
    ball_bouncer #(.H_VISIBLE(15), .INIT_X(1)) d2 (.i_clk(clk), .i_rst(rst), .i_vsync(vsync),
        .i_visible(visible), .i_hpos(hpos), .i_vpos(vpos), .o_rgb(rgb2), .o_ball_x(x2),
        .o_ball_y(y2), .o_bounce(b2), .o_bounce_count(c2));
    ball_bouncer #(.INIT_X(630), .INIT_Y(470)) d3 (.i_clk(clk), .i_rst(rst), .i_vsync(vsync),
        .i_visible(visible), .i_hpos(hpos), .i_vpos(vpos), .o_rgb(rgb3), .o_ball_x(x3),
        .o_ball_y(y3), .o_bounce(b3), .o_bounce_count(c3));

    // count cycles each bounce output is high; a single pulse adds exactly 1
    always @(posedge clk) begin
        if (b0 === 1'b1) nb0++;
        if (b1 === 1'b1) nb1++;
        if (b2 === 1'b1) nb2++;
        if (b3 === 1'b1) nb3++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame();
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pixel(input logic [9:0] h, input logic [9:0] v, input logic vis);
        hpos = h;
        vpos = v;
        visible = vis;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_x", 32'(x0), 128);
        check("rst_y", 32'(y0), 128);
        check("rst_rgb", 32'(rgb0), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_x", 32'(x0), 128);
        check("idle_y", 32'(y0), 128);
        check("idle_cnt", 32'(c0), 0);
        check("idle_bounce", 32'(b0), 0);
        check("idle_nb", 32'(nb0 + nb1 + nb2 + nb3), 0);

        pixel(10'd128, 10'd135, 1'b1);
        check("rgb_in", 32'(rgb0), 32'(COL0));
        pixel(10'd136, 10'd135, 1'b1);
        check("rgb_right_edge", 32'(rgb0), 0);
        pixel(10'd127, 10'd130, 1'b1);
        check("rgb_left_edge", 32'(rgb0), 0);
        pixel(10'd135, 10'd136, 1'b1);
        check("rgb_bottom_edge", 32'(rgb0), 0);
        pixel(10'd135, 10'd128, 1'b1);
        check("rgb_corner_in", 32'(rgb0), 32'(COL0));
        pixel(10'd130, 10'd130, 1'b0);
        check("rgb_invisible", 32'(rgb0), 0);

        frame();
        check("t1_d0_x", 32'(x0), 130);
        check("t1_d0_y", 32'(y0), 130);
        check("t1_d1_x", 32'(x1), 630);
        check("t1_d2_x", 32'(x2), 3);
        check("t1_d3_x", 32'(x3), 632);
        check("t1_d3_y", 32'(y3), 472);
        check("t1_d3_cnt", 32'(c3), 1);
        check("t1_d3_nb", 32'(nb3), 1);
        pixel(10'd632, 10'd472, 1'b1);
        check("t1_d3_rgb", 32'(rgb3), 32'(COL_CORNER));
        pixel(10'd0, 10'd0, 1'b0);

        frame();
        check("t2_d1_x", 32'(x1), 632);
        check("t2_d1_cnt", 32'(c1), 1);
        check("t2_d1_nb", 32'(nb1), 1);
        check("t2_d3_x", 32'(x3), 630);
        check("t2_d3_y", 32'(y3), 470);
        check("t2_d3_cnt", 32'(c3), 1);
        check("t2_d2_x", 32'(x2), 5);

        frame();
        check("t3_d1_x", 32'(x1), 630);
        check("t3_d1_cnt", 32'(c1), 1);
        check("t3_d2_x", 32'(x2), 7);
        check("t3_d2_cnt", 32'(c2), 1);

        frame();
        check("t4_d2_x", 32'(x2), 5);
        frame();
        check("t5_d2_x", 32'(x2), 3);
        frame();
        check("t6_d2_x", 32'(x2), 1);
        check("t6_d2_cnt", 32'(c2), 1);
        frame();
        check("t7_d2_x", 32'(x2), 0);
        check("t7_d2_cnt", 32'(c2), 2);
        check("t7_d2_nb", 32'(nb2), 2);
        frame();
        check("t8_d2_x", 32'(x2), 2);
        check("t8_d0_x", 32'(x0), 144);
        check("t8_d0_nb", 32'(nb0), 0);

        nb0 = 0;
        nb1 = 0;
        nb2 = 0;
        nb3 = 0;
        rst = 1'b1;
        vsync = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rtick_x", 32'(x0), 128);
        check("rtick_y", 32'(y0), 128);
        check("rtick_cnt", 32'(c2), 0);
        check("rtick_d1_x", 32'(x1), 628);
        check("rtick_nb", 32'(nb0 + nb1 + nb2 + nb3), 0);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        frame();
        check("after_rst_x", 32'(x0), 130);
        check("after_rst_d1_x", 32'(x1), 630);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
